// File: rtl/stdp_pkg.sv
// Shared definitions for the STDP sweep controller: sweep FSM states,
// default geometry of one sweep and the epoch counter width.
package stdp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    localparam int STDP_NUM_SYN = 16;
    localparam int STDP_ADDR_W  = 4;
    localparam int STDP_WB_LAT  = 2;
    localparam int STDP_EPOCH_W = 16;

endpackage

// File: rtl/stdp_wb_delay_line.sv
// Write-back alignment line: a DEPTH-stage shift of {valid, addr} so the RAM
// write strobe and address come out exactly when the learning pipeline has the
// updated weight ready. A synchronous clear kills every in-flight write.
module stdp_wb_delay_line #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              vld_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              vld_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [DEPTH-1:0]             vld_p;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_p;

    // Shift {valid, addr} one stage per cycle; clear drops all pending writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p  <= '0;
            addr_p <= '0;
        end else if (clr_i) begin
            vld_p  <= '0;
            addr_p <= '0;
        end else begin
            vld_p[0]  <= vld_i;
            addr_p[0] <= addr_i;
            for (int s = 1; s < DEPTH; s++) begin
                vld_p[s]  <= vld_p[s-1];
                addr_p[s] <= addr_p[s-1];
            end
        end
    end

    assign vld_o  = vld_p[DEPTH-1];
    assign addr_o = addr_p[DEPTH-1];

endmodule

// File: rtl/stdp_sweep_controller.sv
// STDP sweep sequencer: start/busy/done handshake around one pass over all
// synapses. Issues RAM reads, then the delayed write-backs, then a done pulse.
// Optional feature macro: STDP_CTRL_EPOCH_CNT_EN builds the saturating
// completed-sweep counter; without it epoch_cnt is tied to zero.
module stdp_sweep_controller
    import stdp_pkg::*;
#(
    parameter int NUM_SYN = STDP_NUM_SYN,
    parameter int ADDR_W  = STDP_ADDR_W,
    parameter int WB_LAT  = STDP_WB_LAT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic                    capture_en,
    output logic                    busy,
    output logic                    done,
    output logic [STDP_EPOCH_W-1:0] epoch_cnt
);

    localparam int                DRAIN_W    = (WB_LAT > 1) ? $clog2(WB_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_SYN - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(WB_LAT - 1);

    sweep_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rd_en_q, rd_en_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wb_clr;

    // Next-state and registered-output decode; abort only matters mid-sweep.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        wb_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = SWEEP;
            end
            SWEEP: begin
                if (abort) begin
                    state_d = IDLE;
                    wb_clr  = 1'b1;
                end else if (rd_addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                    wb_clr  = 1'b1;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs are computed from the next state so they leave flops directly.
        rd_en_d   = (state_d == SWEEP);
        rd_addr_d = (state_q == SWEEP && state_d == SWEEP) ? rd_addr_q + ADDR_W'(1) : '0;
        busy_d    = (state_d == SWEEP) || (state_d == DRAIN);
        done_d    = (state_d == DONE);
    end

    // Control registers: FSM state, read counter, drain counter, handshake flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            rd_en_q   <= rd_en_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    stdp_wb_delay_line #(
        .DEPTH  (WB_LAT),
        .ADDR_W (ADDR_W)
    ) u_wb_line (
        .clk    (clk),
        .rst_n  (rst),
        .clr_i  (wb_clr),
        .vld_i  (rd_en_q),
        .addr_i (rd_addr_q),
        .vld_o  (wr_en),
        .addr_o (wr_addr)
    );

    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign busy       = busy_q;
    assign capture_en = !busy_q;
    assign done       = done_q;

`ifdef STDP_CTRL_EPOCH_CNT_EN
    logic [STDP_EPOCH_W-1:0] epoch_q, epoch_d;

    function automatic logic [STDP_EPOCH_W-1:0] sat_inc(input logic [STDP_EPOCH_W-1:0] v);
        return (&v) ? v : v + STDP_EPOCH_W'(1);
    endfunction

    // One count per DONE cycle, holding at all-ones.
    always_comb begin
        epoch_d = (state_q == DONE) ? sat_inc(epoch_q) : epoch_q;
    end

    // Completed-sweep counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) epoch_q <= '0;
        else      epoch_q <= epoch_d;
    end

    assign epoch_cnt = epoch_q;
`else
    assign epoch_cnt = '0;
`endif

endmodule

// File: tb/tb_stdp_sweep_controller.sv
// Bench for stdp_sweep_controller: a default instance (16 synapses, latency 2)
// and a small instance (12 synapses, latency 1). Expected reads, writes and
// done pulses are queued when a sweep is launched and retired by monitors.
module tb_stdp_sweep_controller;

    localparam int NA = 16, LA = 2, NB = 12, LB = 1, AW = 4;
    localparam int PA = NA + LA + 2;

    typedef struct { int cyc; int addr; } ev_t;
    typedef struct { int nsw; int abort_off; int wcount; int rcount; int ndone; int epoch_inc; } row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, b_start = 1'b0, b_abort = 1'b0;

    logic          a_rd_en, a_wr_en, a_capture_en, a_busy, a_done;
    logic [AW-1:0] a_rd_addr, a_wr_addr;
    logic [15:0]   a_epoch_cnt;
    logic          b_rd_en, b_wr_en, b_capture_en, b_busy, b_done;
    logic [AW-1:0] b_rd_addr, b_wr_addr;
    logic [15:0]   b_epoch_cnt;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int exp_epoch = 0;
    int exp_epoch_b = 0;
    ev_t rdq_a[$], wrq_a[$], rdq_b[$], wrq_b[$];
    int  dnq_a[$], dnq_b[$];
    row_t rows[5];

    stdp_sweep_controller u_dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
        .capture_en(a_capture_en), .busy(a_busy), .done(a_done), .epoch_cnt(a_epoch_cnt)
    );

    stdp_sweep_controller #(.NUM_SYN(NB), .ADDR_W(AW), .WB_LAT(LB)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .capture_en(b_capture_en), .busy(b_busy), .done(b_done), .epoch_cnt(b_epoch_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Retire events of instance A against the queued expectations.
    always @(negedge clk) begin
        ev_t e;
        if (a_rd_en) begin
            if (rdq_a.size() == 0) chk("a_rd_unexpected", int'(a_rd_addr), -1);
            else begin
                e = rdq_a.pop_front();
                chk("a_rd_cyc", cyc, e.cyc);
                chk("a_rd_addr", int'(a_rd_addr), e.addr);
            end
        end else begin
            chk("a_rd_addr_idle", int'(a_rd_addr), 0);
        end
        if (a_wr_en) begin
            if (wrq_a.size() == 0) chk("a_wr_unexpected", int'(a_wr_addr), -1);
            else begin
                e = wrq_a.pop_front();
                chk("a_wr_cyc", cyc, e.cyc);
                chk("a_wr_addr", int'(a_wr_addr), e.addr);
            end
        end
        if (a_done) begin
            if (dnq_a.size() == 0) chk("a_done_unexpected", cyc, -1);
            else chk("a_done_cyc", cyc, dnq_a.pop_front());
        end
    end

    // Retire events of instance B against the queued expectations.
    always @(negedge clk) begin
        ev_t e;
        if (b_rd_en) begin
            if (rdq_b.size() == 0) chk("b_rd_unexpected", int'(b_rd_addr), -1);
            else begin
                e = rdq_b.pop_front();
                chk("b_rd_cyc", cyc, e.cyc);
                chk("b_rd_addr", int'(b_rd_addr), e.addr);
            end
        end
        if (b_wr_en) begin
            if (wrq_b.size() == 0) chk("b_wr_unexpected", int'(b_wr_addr), -1);
            else begin
                e = wrq_b.pop_front();
                chk("b_wr_cyc", cyc, e.cyc);
                chk("b_wr_addr", int'(b_wr_addr), e.addr);
            end
        end
        if (b_done) begin
            if (dnq_b.size() == 0) chk("b_done_unexpected", cyc, -1);
            else chk("b_done_cyc", cyc, dnq_b.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic push_sweep_a(input int ks, input int nrd, input int nwr, input bit dn);
        ev_t e;
        for (int i = 0; i < nrd; i++) begin e.cyc = ks + i;      e.addr = i; rdq_a.push_back(e); end
        for (int i = 0; i < nwr; i++) begin e.cyc = ks + LA + i; e.addr = i; wrq_a.push_back(e); end
        if (dn) dnq_a.push_back(ks + NA + LA);
    endtask

    task automatic chk_rst_a();
        chk("rst_a_rd_en", int'(a_rd_en), 0);
        chk("rst_a_rd_addr", int'(a_rd_addr), 0);
        chk("rst_a_wr_en", int'(a_wr_en), 0);
        chk("rst_a_wr_addr", int'(a_wr_addr), 0);
        chk("rst_a_busy", int'(a_busy), 0);
        chk("rst_a_done", int'(a_done), 0);
        chk("rst_a_capture", int'(a_capture_en), 1);
        chk("rst_a_epoch", int'(a_epoch_cnt), 0);
    endtask

    task automatic run_row_a(input row_t r);
        int ks, ks_last;
        @(negedge clk);
        start = 1'b1;
        ks = cyc + 1;
        for (int s = 0; s < r.nsw; s++)
            push_sweep_a(ks + s * PA, r.rcount, r.wcount, s < r.ndone);
        ks_last = ks + (r.nsw - 1) * PA;
        @(negedge clk);
        while (cyc < ks_last) @(negedge clk);
        start = 1'b0;
        if (r.abort_off >= 0) begin
            while (cyc < ks + r.abort_off) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_busy", int'(a_busy), 0);
            chk("abort_wr_en", int'(a_wr_en), 0);
        end
        while (cyc < ks_last + PA) @(negedge clk);
`ifdef STDP_CTRL_EPOCH_CNT_EN
        exp_epoch += r.epoch_inc;
`endif
        chk("row_epoch", int'(a_epoch_cnt), exp_epoch);
        chk("row_idle_busy", int'(a_busy), 0);
    endtask

    task automatic seq_busy_window();
        int ks;
        logic exp_b;
        @(negedge clk);
        start = 1'b1;
        ks = cyc + 1;
        push_sweep_a(ks, NA, NA, 1'b1);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= NA + LA + 1; c++) begin
            exp_b = (c < NA + LA);
            chk("win_busy", int'(a_busy), int'(exp_b));
            chk("win_capture", int'(a_capture_en), int'(!exp_b));
            @(negedge clk);
        end
`ifdef STDP_CTRL_EPOCH_CNT_EN
        exp_epoch += 1;
`endif
        chk("win_epoch", int'(a_epoch_cnt), exp_epoch);
    endtask

    task automatic seq_start_rules();
        int ks;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        ks = cyc + 1;
        push_sweep_a(ks, NA, NA, 1'b1);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        while (cyc < ks + 5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < ks + PA) @(negedge clk);
`ifdef STDP_CTRL_EPOCH_CNT_EN
        exp_epoch += 1;
`endif
        chk("rules_epoch", int'(a_epoch_cnt), exp_epoch);
        chk("rules_busy", int'(a_busy), 0);
    endtask

    task automatic seq_reset_drain();
        int ks;
        @(negedge clk);
        start = 1'b1;
        ks = cyc + 1;
        push_sweep_a(ks, NA, NA - 1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        while (cyc < ks + NA) @(negedge clk);
        chk("drain_busy_before_rst", int'(a_busy), 1);
        #1 rst = 1'b0;
        #1 chk_rst_a();
        @(negedge clk);
        #1 rst = 1'b1;
        exp_epoch = 0;
    endtask

    task automatic seq_b();
        int ks;
        ev_t e;
        @(negedge clk);
        b_start = 1'b1;
        ks = cyc + 1;
        for (int i = 0; i < NB; i++) begin e.cyc = ks + i;      e.addr = i; rdq_b.push_back(e); end
        for (int i = 0; i < NB; i++) begin e.cyc = ks + LB + i; e.addr = i; wrq_b.push_back(e); end
        dnq_b.push_back(ks + NB + LB);
        @(negedge clk);
        b_start = 1'b0;
        while (cyc < ks + NB + LB + 3) @(negedge clk);
`ifdef STDP_CTRL_EPOCH_CNT_EN
        exp_epoch_b += 1;
`endif
        chk("b_epoch", int'(b_epoch_cnt), exp_epoch_b);
        chk("b_busy_after", int'(b_busy), 0);
        chk("b_capture_after", int'(b_capture_en), 1);
    endtask

    initial begin
        //         nsw abort wcnt rcnt ndone epoch
        rows[0] = '{1, -1, 16, 16, 1, 1};
        rows[1] = '{3, -1, 16, 16, 3, 3};
        rows[2] = '{1,  7,  6,  8, 0, 0};
        rows[3] = '{1, 17, 16, 16, 0, 0};
        rows[4] = '{1,  0,  0,  1, 0, 0};

        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_rst_a();
        chk("rst_b_rd_en", int'(b_rd_en), 0);
        chk("rst_b_wr_en", int'(b_wr_en), 0);
        chk("rst_b_busy", int'(b_busy), 0);
        chk("rst_b_done", int'(b_done), 0);
        chk("rst_b_capture", int'(b_capture_en), 1);
        chk("rst_b_epoch", int'(b_epoch_cnt), 0);
        #1 rst = 1'b1;

        seq_busy_window();
        for (int r = 0; r < 5; r++) run_row_a(rows[r]);
        seq_start_rules();
        seq_reset_drain();
        run_row_a(rows[0]);
        seq_b();

        repeat (5) @(negedge clk);
        chk("left_rd_a", rdq_a.size(), 0);
        chk("left_wr_a", wrq_a.size(), 0);
        chk("left_done_a", dnq_a.size(), 0);
        chk("left_rd_b", rdq_b.size(), 0);
        chk("left_wr_b", wrq_b.size(), 0);
        chk("left_done_b", dnq_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stdp_sweep_controller.md
# stdp_sweep_controller

Sequencer for the STDP learning datapath. One sweep walks all synapses in order: it issues the weight-RAM read address and the pre-synaptic mux select, then raises the RAM write enable with the address delayed to line up with the write-back pipeline (RAM read, then timing-difference encoder, LUT and adder registers). It sits between the neuron-level control (start, abort) and the weight RAM, mux and shift registers, and replaces free-running counters with a start/busy/done handshake.

## Interface
- `NUM_SYN`, 16: synapses per sweep; must be at least 2.
- `ADDR_W`, 4: address width; `2**ADDR_W` must be at least `NUM_SYN`.
- `WB_LAT`, 2: cycles from `rd_addr` being valid to the matching write-back; range 1..8.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  sweep request; sampled only in IDLE.
- `abort`  in  1  cancel the sweep in progress; synchronous.
- `rd_en`  out  1  RAM read strobe.
- `rd_addr`  out  ADDR_W  RAM read address; also drives the pre-synaptic mux select.
- `wr_en`  out  1  RAM write enable.
- `wr_addr`  out  ADDR_W  RAM write address.
- `capture_en`  out  1  shift-register capture enable; low while the sweep reads shift-register contents.
- `busy`  out  1  a sweep is in progress.
- `done`  out  1  one-cycle pulse after the last write.
- `epoch_cnt`  out  16  number of completed sweeps.

## Operation
- States:
  - IDLE -> SWEEP on `start`.
  - SWEEP -> DRAIN after `rd_addr` has issued `NUM_SYN-1`.
  - DRAIN -> DONE after `WB_LAT` cycles.
  - DONE -> IDLE unconditionally.
- Read counter:
  - In SWEEP, `rd_addr` counts 0..`NUM_SYN-1`, one step per cycle, with `rd_en`=1.
  - Outside SWEEP, `rd_en`=0 and `rd_addr` holds 0.
- Write-back pipeline:
  - A `WB_LAT`-deep shift line carries {valid, addr}.
  - `wr_en` and `wr_addr` are its output stage.
  - The line keeps shifting in DRAIN.
- `busy` = (state is SWEEP or DRAIN). `capture_en` = !`busy`.
- `done` = (state is DONE).
- `epoch_cnt` increments once per DONE cycle and saturates at 0xFFFF.
- `start` outside IDLE is ignored; it is not queued.
- `abort` in SWEEP or DRAIN:
  - Next state is IDLE.
  - All pipeline valid bits are cleared, so no further `wr_en` is issued.
  - No `done` pulse; `epoch_cnt` is unchanged.
  - `abort` in IDLE or DONE has no effect.
- `start` and `abort` high together in IDLE: `start` wins, because `abort` is ignored in IDLE.
- Writes are never issued to addresses at or above `NUM_SYN`.
- Read-after-write: a new sweep cannot begin until every write of the previous sweep has retired, which DONE guarantees.

## Timing
- Reset values: state IDLE, all pipeline valid bits 0, `rd_en`=0, `rd_addr`=0, `wr_en`=0, `wr_addr`=0, `busy`=0, `done`=0, `capture_en`=1, `epoch_cnt`=0.
- Take `start` sampled high at edge k:
  - Cycle k+1+i, for i in 0..`NUM_SYN-1`: `rd_addr`=i.
  - Cycle k+1+`WB_LAT`+i: `wr_en`=1, `wr_addr`=i.
  - `busy` is high in cycles k+1 .. k+`NUM_SYN`+`WB_LAT`.
  - `done` is high in cycle k+`NUM_SYN`+`WB_LAT`+1.
  - Earliest next accepted `start` is at edge k+`NUM_SYN`+`WB_LAT`+2.
- Sweep period is `NUM_SYN`+`WB_LAT`+2 cycles including DONE and one IDLE cycle (20 with defaults).
- `abort` sampled at edge j: in cycle j+1, `busy`=0 and `wr_en`=0.
- Reset asserted mid-sweep: all outputs go to their reset values immediately, without waiting for a clock edge.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `STDP_CTRL_EPOCH_CNT_EN` defined: the 16-bit saturating `epoch_cnt` register is built as described.
- Undefined: no counter flops are built and `epoch_cnt` is tied to 0; all other behaviour is identical.

## Structure
- Shared package `stdp_pkg` holds:
  - the state enum `sweep_state_t` (IDLE, SWEEP, DRAIN, DONE);
  - the defaults `STDP_NUM_SYN`=16, `STDP_ADDR_W`=4, `STDP_WB_LAT`=2;
  - the epoch-count width constant.
- One sub-module: `stdp_wb_delay_line`, parameterised by depth and address width, with a synchronous clear. It is the {valid, addr} shift line.
- The FSM, read counter and epoch counter stay in the top.

## Test plan
- Reset, then `start` for one cycle:
  - `rd_addr` runs 0..15 on consecutive cycles;
  - `wr_en` is high for exactly 16 cycles with `wr_addr` 0..15, starting 2 cycles after `rd_addr`=0;
  - `done` fires once, 19 cycles after the `start` edge;
  - `epoch_cnt`=1.
- `start` held high continuously:
  - back-to-back sweeps with no gaps or overlaps;
  - `done` pulses 20 cycles apart;
  - `epoch_cnt` increments once per sweep.
- `abort` pulsed when `rd_addr`=7:
  - the next cycle has `busy`=0 and `wr_en`=0;
  - only addresses 0..5 were written, because the address 6 write-back is killed;
  - no `done`; `epoch_cnt` unchanged.
- `rst` driven low asynchronously mid-DRAIN:
  - all outputs reach their reset values before the next edge;
  - after release, a fresh `start` yields a complete, correct sweep.
- `WB_LAT`=1 and `NUM_SYN`=12:
  - writes to 0..11 lag reads by 1 cycle;
  - `done` fires 14 cycles after `start`;
  - no writes to address 12 or above.
- Build without `STDP_CTRL_EPOCH_CNT_EN`: `epoch_cnt` stays 0 through 3 sweeps while all handshake timing matches the default build.
